// File: rtl/conv_row_streamer.sv
// conv_row_streamer: frames an unframed pixel stream into rows for the line buffer.
// Each row is followed by one row_complete cycle and a fixed idle gap; zero rows form the vertical pad.
module conv_row_streamer #(
  parameter int DATA_W      = 8,
  parameter int KER_SIZE    = 3,
  parameter int INPUT_X_DIM = 3,
  parameter int INPUT_Y_DIM = 3,
  parameter int PAD         = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              pad_row,
  output logic              row_complete,
  output logic [7:0]        row_idx,
  output logic              busy,
  output logic              frame_done
);

  localparam int ROWS = INPUT_Y_DIM + 2 * PAD;
  localparam int RMAX = (PAD > INPUT_Y_DIM) ? PAD : INPUT_Y_DIM;
  localparam int GMAX = (KER_SIZE > 1) ? KER_SIZE - 1 : 1;
  localparam int CW   = $clog2(INPUT_X_DIM + 1);
  localparam int RCW  = $clog2(RMAX + 1);
  localparam int IW   = $clog2(ROWS + 1);
  localparam int GW   = $clog2(GMAX + 1);

  localparam logic [CW-1:0]  X_LAST = CW'(INPUT_X_DIM - 1);
  localparam logic [CW-1:0]  X_DIM  = CW'(INPUT_X_DIM);
  localparam logic [RCW-1:0] Y_LAST = RCW'(INPUT_Y_DIM - 1);
  localparam logic [RCW-1:0] P_LAST = RCW'((PAD > 0) ? PAD - 1 : 0);
  localparam logic [GW-1:0]  G_LAST = GW'((KER_SIZE > 1) ? KER_SIZE - 2 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TOP,
    S_DATA,
    S_BOT,
    S_RC,
    S_GAP,
    S_FIN
  } state_t;

  state_t            state_q, state_d;
  state_t            region_q, region_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RCW-1:0]    row_q, row_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              pad_q, pad_d;
  logic              rc_q, rc_d;
  logic              busy_q, busy_d;
  logic              fd_q, fd_d;
  logic              row_end;
  logic              region_last;

  assign s_ready = (state_q == S_DATA) && (col_q < X_DIM);

  // With a 1-wide kernel there is no gap: the next row follows row_complete.
  assign row_end = (state_q == S_GAP && gap_q == G_LAST) ||
                   (state_q == S_RC && KER_SIZE == 1);

  assign region_last = (region_q == S_DATA) ? (row_q == Y_LAST)
                                            : (row_q == P_LAST);

  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    col_d    = col_q;
    row_d    = row_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    valid_d  = 1'b0;
    data_d   = '0;
    pad_d    = pad_q;
    rc_d     = 1'b0;
    busy_d   = busy_q;
    fd_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start && !busy_q) begin
          busy_d = 1'b1;
          col_d  = '0;
          row_d  = '0;
          idx_d  = '0;
          if (PAD > 0) begin
            state_d  = S_TOP;
            region_d = S_TOP;
            pad_d    = 1'b1;
          end else begin
            state_d  = S_DATA;
            region_d = S_DATA;
            pad_d    = 1'b0;
          end
        end
      end
      S_TOP, S_BOT: begin
        valid_d = 1'b1;
        col_d   = col_q + 1'b1;
        if (col_q == X_LAST) state_d = S_RC;
      end
      S_DATA: begin
        if (s_ready && s_valid) begin
          valid_d = 1'b1;
          data_d  = s_data;
          col_d   = col_q + 1'b1;
          if (col_q == X_LAST) state_d = S_RC;
        end
      end
      S_RC: begin
        rc_d    = 1'b1;
        col_d   = '0;
        gap_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        gap_d = gap_q + 1'b1;
      end
      S_FIN: begin
        fd_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (row_end) begin
      if (!region_last) begin
        state_d = region_q;
        row_d   = row_q + 1'b1;
        idx_d   = idx_q + 1'b1;
      end else begin
        row_d = '0;
        unique case (region_q)
          S_TOP: begin
            state_d  = S_DATA;
            region_d = S_DATA;
            pad_d    = 1'b0;
            idx_d    = idx_q + 1'b1;
          end
          S_DATA: begin
            if (PAD > 0) begin
              state_d  = S_BOT;
              region_d = S_BOT;
              pad_d    = 1'b1;
              idx_d    = idx_q + 1'b1;
            end else begin
              state_d = S_FIN;
              pad_d   = 1'b0;
              idx_d   = '0;
            end
          end
          default: begin
            state_d = S_FIN;
            pad_d   = 1'b0;
            idx_d   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      region_q <= S_IDLE;
      col_q    <= '0;
      row_q    <= '0;
      idx_q    <= '0;
      gap_q    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      pad_q    <= 1'b0;
      rc_q     <= 1'b0;
      busy_q   <= 1'b0;
      fd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      col_q    <= col_d;
      row_q    <= row_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      pad_q    <= pad_d;
      rc_q     <= rc_d;
      busy_q   <= busy_d;
      fd_q     <= fd_d;
    end
  end

  assign valid        = valid_q;
  assign data         = data_q;
  assign pad_row      = pad_q;
  assign row_complete = rc_q;
  assign row_idx      = 8'(idx_q);
  assign busy         = busy_q;
  assign frame_done   = fd_q;

endmodule

// File: tb/tb_conv_row_streamer.sv
// tb_conv_row_streamer: directed frames with random pixels and stalls,
// checked against a row/gap timing model of the framed output stream.
module tb_conv_row_streamer;

  localparam int DW   = 8;
  localparam int K    = 3;
  localparam int X    = 3;
  localparam int Y    = 3;
  localparam int P    = 1;
  localparam int ROWS = Y + 2 * P;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic          start;
  logic [DW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic          valid;
  logic [DW-1:0] data;
  logic          pad_row;
  logic          row_complete;
  logic [7:0]    row_idx;
  logic          busy;
  logic          frame_done;

  logic          b_start;
  logic [DW-1:0] b_s_data;
  logic          b_s_valid;
  logic          b_s_ready;
  logic          b_valid;
  logic [DW-1:0] b_data;
  logic          b_pad_row;
  logic          b_row_complete;
  logic [7:0]    b_row_idx;
  logic          b_busy;
  logic          b_frame_done;

  conv_row_streamer #(
    .DATA_W(DW), .KER_SIZE(K), .INPUT_X_DIM(X),
    .INPUT_Y_DIM(Y), .PAD(P)
  ) u_dut (
    .clk(clk), .rstn(rstn), .start(start),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .valid(valid), .data(data), .pad_row(pad_row),
    .row_complete(row_complete), .row_idx(row_idx),
    .busy(busy), .frame_done(frame_done)
  );

  conv_row_streamer #(
    .DATA_W(DW), .KER_SIZE(K), .INPUT_X_DIM(X),
    .INPUT_Y_DIM(Y), .PAD(0)
  ) u_dut_b (
    .clk(clk), .rstn(rstn), .start(b_start),
    .s_data(b_s_data), .s_valid(b_s_valid), .s_ready(b_s_ready),
    .valid(b_valid), .data(b_data), .pad_row(b_pad_row),
    .row_complete(b_row_complete), .row_idx(b_row_idx),
    .busy(b_busy), .frame_done(b_frame_done)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            vc_q[$];
  int            vd_q[$];
  bit            vp_q[$];
  int            vr_q[$];
  int            rc_q[$];
  int            fd_q[$];
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_src[$];
  int            mode, stall_left, acc_n, busy_on, busy_off;
  bit            acc, busy_prev;
  int            b_nv, b_npad, b_nrc, b_fd, b_first, b_cnt, b_exp;
  bit            b_acc;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample both DUTs at the falling edge, then drive inputs.
  task automatic step();
    @(negedge clk);
    if (valid) begin
      vc_q.push_back(cyc);
      vd_q.push_back(int'(data));
      vp_q.push_back(pad_row);
      vr_q.push_back(int'(row_idx));
    end
    if (row_complete) rc_q.push_back(cyc);
    if (frame_done) fd_q.push_back(cyc);
    if (busy && !busy_prev) busy_on = cyc;
    if (!busy && busy_prev) busy_off = cyc;
    busy_prev = busy;
    if (acc && src_q.size() > 0) begin
      void'(src_q.pop_front());
      acc_n++;
      if (mode == 2 && acc_n == 2) stall_left = 2;
    end
    if (stall_left > 0) begin
      s_valid = 1'b0;
      stall_left--;
    end else if (mode == 1) begin
      s_valid = ($urandom_range(0, 3) != 0);
    end else begin
      s_valid = 1'b1;
    end
    s_data = (src_q.size() > 0) ? src_q[0] : 8'hEE;
    acc = s_valid && s_ready;
    if (b_valid) begin
      if (b_nv == 0) b_first = cyc;
      b_nv++;
      chk("b_data", int'(b_data), b_exp);
      b_exp = (b_exp + 1) % 256;
    end
    if (b_pad_row) b_npad++;
    if (b_row_complete) b_nrc++;
    if (b_frame_done) b_fd = cyc;
    if (b_acc) b_cnt = (b_cnt + 1) % 256;
    b_s_valid = 1'b1;
    b_s_data = DW'(b_cnt);
    b_acc = b_s_ready;
  endtask

  task automatic check_frame(input int st, input int md);
    int lo, hi, nxt, expd;
    bit pad, npad;
    chk("valid_count", vc_q.size(), ROWS * X);
    chk("rc_count", rc_q.size(), ROWS);
    chk("fd_count", fd_q.size(), 1);
    if (vc_q.size() != ROWS * X || rc_q.size() != ROWS ||
        fd_q.size() != 1) return;
    for (int i = 0; i < ROWS * X; i++) begin
      pad  = (i / X < P) || (i / X >= P + Y);
      expd = pad ? 0 : int'(exp_src[i - P * X]);
      chk("pix_data", vd_q[i], expd);
      chk("pix_pad", int'(vp_q[i]), int'(pad));
      chk("pix_row", vr_q[i], i / X);
    end
    chk("first_valid", vc_q[0] - st, 1);
    for (int r = 0; r < ROWS; r++) begin
      pad = (r < P) || (r >= P + Y);
      lo  = vc_q[r * X];
      hi  = vc_q[r * X + X - 1];
      if (pad || md == 0) chk("row_contig", hi - lo, X - 1);
      chk("rc_after_last", rc_q[r] - hi, 1);
      if (r < ROWS - 1) begin
        nxt  = vc_q[(r + 1) * X];
        npad = (r + 1 < P) || (r + 1 >= P + Y);
        if (md != 1 || npad) chk("gap_exact", nxt - rc_q[r], K);
        else chk("gap_min", int'(nxt - rc_q[r] >= K), 1);
      end
    end
    if (md == 2) chk("stall_hole", vc_q[P * X + 2] - vc_q[P * X + 1], 3);
    chk("fd_after_rc", fd_q[0] - rc_q[ROWS - 1], K);
    if (md == 0) chk("fd_abs", fd_q[0] - st, 31);
    chk("busy_rise", busy_on - st, 0);
    chk("busy_fall", busy_off - fd_q[0], 1);
  endtask

  task automatic clear_cap();
    vc_q.delete();
    vd_q.delete();
    vp_q.delete();
    vr_q.delete();
    rc_q.delete();
    fd_q.delete();
  endtask

  task automatic run(input int md, input bit seq, input bit poke);
    int st, n;
    logic [DW-1:0] v;
    clear_cap();
    src_q.delete();
    exp_src.delete();
    for (int i = 0; i < X * Y; i++) begin
      v = seq ? DW'(i + 1) : DW'($urandom_range(0, 255));
      src_q.push_back(v);
      exp_src.push_back(v);
    end
    mode = md;
    acc_n = 0;
    stall_left = 0;
    acc = 1'b0;
    busy_on = -1;
    busy_off = -1;
    step();
    start = 1'b1;
    st = cyc + 1;
    step();
    start = 1'b0;
    n = 0;
    while (fd_q.size() == 0 && n < 400) begin
      step();
      n++;
      start = poke && (cyc == st + 10 || frame_done);
    end
    repeat (12) begin
      step();
      start = 1'b0;
    end
    check_frame(st, md);
  endtask

  initial begin
    int n, bst;
    rstn = 1'b0;
    start = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    b_start = 1'b0;
    b_s_valid = 1'b0;
    b_s_data = '0;
    acc = 1'b0;
    busy_prev = 1'b0;
    mode = 0;
    stall_left = 0;
    acc_n = 0;
    b_cnt = 10;
    b_exp = 10;
    b_acc = 1'b0;
    b_nv = 0;
    b_npad = 0;
    b_nrc = 0;
    b_fd = -1;
    b_first = -1;
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sready", int'(s_ready), 0);
    chk("rst_row_idx", int'(row_idx), 0);
    chk("rst_b_busy", int'(b_busy), 0);
    rstn = 1'b1;

    run(0, 1'b1, 1'b0);
    run(2, 1'b0, 1'b0);

    b_nv = 0;
    b_npad = 0;
    b_nrc = 0;
    b_fd = -1;
    b_exp = b_cnt;
    step();
    b_start = 1'b1;
    bst = cyc + 1;
    step();
    b_start = 1'b0;
    n = 0;
    while (b_fd < 0 && n < 200) begin
      step();
      n++;
    end
    repeat (4) step();
    chk("b_valid_count", b_nv, 9);
    chk("b_pad_seen", b_npad, 0);
    chk("b_rc_count", b_nrc, 3);
    chk("b_first_valid", b_first - bst, 1);
    chk("b_fd_abs", b_fd - bst, 19);

    run(0, 1'b0, 1'b1);

    clear_cap();
    mode = 0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!(valid && row_idx == 8'd2) && n < 100) begin
      step();
      n++;
    end
    chk("reach_row2", int'(n < 100), 1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_valid", int'(valid), 0);
    chk("arst_data", int'(data), 0);
    chk("arst_pad", int'(pad_row), 0);
    chk("arst_rc", int'(row_complete), 0);
    chk("arst_row_idx", int'(row_idx), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_fd", int'(frame_done), 0);
    chk("arst_sready", int'(s_ready), 0);
    clear_cap();
    step();
    rstn = 1'b1;
    repeat (4) step();
    chk("abort_quiet", rc_q.size() + fd_q.size() + vc_q.size(), 0);
    run(1, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) run(1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
